game_scheduler: RTL
===================

# game_scheduler

Parametrised turn scheduler for an N-player board game; successor of the fixed four-player top-level turn logic. Rotates the active turn among unfinished players on a prescaled tick, detects per-player finish codes, records the finish order, skips finished players and declares game over. Sits between the per-player game logic instances and the display/status outputs.

## Interface
- N_PLAYERS, 4: player count, 1..16; ID_W = max(1, clog2(N_PLAYERS)).
- DIV, 10000: prescaler terminal count per turn slice, ≥2.
- STATUS_W, 4: per-player status code width.
- POS_W, 3: per-player position width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; begins a game from IDLE or OVER.
- status_in  in  N_PLAYERS*STATUS_W  packed status codes, player i at [i*STATUS_W +: STATUS_W].
- position_in  in  N_PLAYERS*POS_W  packed positions, same packing.
- enable  out  N_PLAYERS  one-hot turn enable to player logic.
- win_pulse  out  1  one-cycle pulse on each recorded finish.
- cur_player  out  ID_W  index of the player holding the turn.
- status_code  out  STATUS_W  status_in slice of cur_player.
- position  out  POS_W  position_in slice of cur_player.
- finished  out  N_PLAYERS  finished-player mask.
- finish_count  out  clog2(N_PLAYERS+1)  number of ranked players.
- rank_order  out  N_PLAYERS*ID_W  slot k = index of k-th finisher; unused slots 0.
- game_over  out  1  high in OVER.

## Operation
- FSM states: IDLE, PLAY, OVER.
- IDLE: enable all 0, prescaler held at 0; start=1 → PLAY, cur_player=0.
- PLAY: prescaler counts 0..DIV-1; at DIV-1 it wraps to 0 and cur_player advances to the next unfinished index, searching circularly from cur_player+1. If no other unfinished player exists, cur_player holds.
- enable[i] = (state==PLAY) & (cur_player==i) & ~finished[i]. This is combinational.
- A finish is status_code[2]==1 while in PLAY with ~finished[cur_player]. On the next edge: set finished[cur_player]; write cur_player into rank_order slot finish_count; increment finish_count; pulse win_pulse; advance cur_player immediately; reset the prescaler to 0.
- A finish and a prescaler wrap in the same cycle: the finish wins, and the player advances exactly once.
- Game end is governed by the configuration macro (see below). On entering OVER, enable goes to 0 and cur_player holds.
- OVER: start=1 clears finished, finish_count, rank_order and the prescaler, then re-enters PLAY with cur_player=0.
- start is ignored in PLAY. There is no restart mid-game.
- N_PLAYERS=1: the first finish goes straight to OVER.

## Timing
- All outputs are reset to 0 and state is reset to IDLE, asynchronously on rst.
- rst mid-game aborts the game with no pulse and no partial-rank retention.
- Latency: finish visible on status_in → finished, rank_order and win_pulse updated 1 cycle later. enable drops in that same cycle.
- win_pulse is exactly 1 cycle per finish, and never 2 consecutive cycles for the same player.
- Turn slice is DIV cycles. It is shortened when the holder finishes.
- status_code and position are combinational muxes of the registered cur_player.

## Configuration
- GAME_SCHED_AUTORANK_EN defined: when finish_count reaches N_PLAYERS-1, the remaining unfinished player is appended to rank_order in the same update. finish_count then equals N_PLAYERS, all finished bits are set, and the FSM enters OVER. Only the real finisher produces win_pulse.
- Undefined: play continues until all N_PLAYERS finish through their own status codes. OVER is entered on the update that makes finish_count == N_PLAYERS.

## Structure
- Shared package game_pkg holds:
  - the state enum (IDLE/PLAY/OVER);
  - STATUS_FINISH_BIT=2;
  - the ID-width helper function.
- One sub-module, next_player_pick: combinational circular priority search. Inputs are finished and cur_player; outputs are next index and a none-left flag.
- Prescaler, FSM and rank registers live in game_scheduler.

## Test plan
All scenarios use N_PLAYERS=4 and DIV=4.
- Reset/idle: rst pulse, start=0 for 20 cycles → all outputs 0, enable=0000.
- Rotation: start=1, no finishes → cur_player steps 0,1,2,3,0 every 4 cycles; enable is one-hot and matches.
- Finish and skip: drive status_in[player 1]=4'b0100 during player 1's turn → 1 cycle later finished=0010, rank_order slot0=1, single win_pulse, cur_player=2. Subsequent rotation is 2,3,0,2.
- Simultaneous: player 2's finish lands on prescaler cycle 3 → cur_player goes to 3, not 0. Exactly one win_pulse.
- Game end, finish order 1,3,0:
  - AUTORANK_EN → finish_count=4, rank_order 1,3,0,2, game_over, 3 win_pulses.
  - Without the macro → game_over only after player 2 finishes.
- Restart/abort:
  - start in OVER → clean PLAY with cur_player=0 and counts cleared.
  - rst asserted mid-PLAY → immediate all-zero outputs.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the turn scheduler and its next-player search.
// Holds the FSM state enum, the finish-bit position and the player-ID width helper.
// Pure declarations: no logic, no latency, no flow control.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Bit of a player's status code that signals "this player has finished".
  localparam int STATUS_FINISH_BIT = 2;

  // Player index width; a single player still needs a one-bit index.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/next_player_pick.sv
// Circular priority search for the next unfinished player after the current one.
// Latency: purely combinational.
// No flow control; none_left_o flags that no other unfinished player exists.
module next_player_pick
  import game_pkg::*;
#(
  parameter int N_PLAYERS = 4,
  parameter int ID_W      = id_width(N_PLAYERS)
) (
  input  logic [N_PLAYERS-1:0] finished_i,
  input  logic [ID_W-1:0]      cur_player_i,
  output logic [ID_W-1:0]      next_o,
  output logic                 none_left_o
);

  int idx;

  // Walk distances from farthest to nearest so the nearest unfinished player wins.
  always_comb begin
    next_o      = cur_player_i;
    none_left_o = 1'b1;
    idx         = 0;
    for (int d = N_PLAYERS - 1; d >= 1; d--) begin
      idx = int'(cur_player_i) + d;
      if (idx >= N_PLAYERS) begin
        idx = idx - N_PLAYERS;
      end
      if (!finished_i[idx[ID_W-1:0]]) begin
        next_o      = idx[ID_W-1:0];
        none_left_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/game_scheduler.sv
// Turn scheduler: rotates the turn over unfinished players each DIV-cycle slice, ranks finishers.
// Latency: a finish seen on status_in updates finished/rank_order/win_pulse one cycle later.
// No backpressure; start is a level sampled only in IDLE/OVER. Macro GAME_SCHED_AUTORANK_EN auto-ranks the last player.
module game_scheduler
  import game_pkg::*;
#(
  parameter  int N_PLAYERS = 4,
  parameter  int DIV       = 10000,
  parameter  int STATUS_W  = 4,
  parameter  int POS_W     = 3,
  localparam int ID_W      = id_width(N_PLAYERS),
  localparam int CNT_W     = $clog2(N_PLAYERS + 1),
  localparam int PRE_W     = $clog2(DIV)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_PLAYERS*STATUS_W-1:0] status_in,
  input  logic [N_PLAYERS*POS_W-1:0]    position_in,
  output logic [N_PLAYERS-1:0]          enable,
  output logic                          win_pulse,
  output logic [ID_W-1:0]               cur_player,
  output logic [STATUS_W-1:0]           status_code,
  output logic [POS_W-1:0]              position,
  output logic [N_PLAYERS-1:0]          finished,
  output logic [CNT_W-1:0]              finish_count,
  output logic [N_PLAYERS*ID_W-1:0]     rank_order,
  output logic                          game_over
);

  state_e                    state_q, state_d;
  logic [ID_W-1:0]           cur_q, cur_d;
  logic [PRE_W-1:0]          presc_q, presc_d;
  logic [N_PLAYERS-1:0]      finished_q, finished_d;
  logic [CNT_W-1:0]          count_q, count_d, count_inc;
  logic [N_PLAYERS*ID_W-1:0] rank_q, rank_d;
  logic                      win_q, win_d;

  logic [N_PLAYERS-1:0]      cur_onehot;
  logic [ID_W-1:0]           pick_next;
  logic                      pick_none;
  logic                      fin_now;

  next_player_pick #(
    .N_PLAYERS (N_PLAYERS),
    .ID_W      (ID_W)
  ) u_pick (
    .finished_i   (finished_q),
    .cur_player_i (cur_q),
    .next_o       (pick_next),
    .none_left_o  (pick_none)
  );

  // Decode the turn holder into a one-hot mask.
  always_comb begin
    cur_onehot = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      cur_onehot[i] = (cur_q == ID_W'(i));
    end
  end

  assign status_code  = status_in[cur_q*STATUS_W +: STATUS_W];
  assign position     = position_in[cur_q*POS_W +: POS_W];
  assign enable       = (state_q == ST_PLAY) ? (cur_onehot & ~finished_q) : '0;
  assign win_pulse    = win_q;
  assign cur_player   = cur_q;
  assign finished     = finished_q;
  assign finish_count = count_q;
  assign rank_order   = rank_q;
  assign game_over    = (state_q == ST_OVER);

  assign count_inc = count_q + CNT_W'(1);
  // A finish only counts once per player, and only while a game is running.
  assign fin_now   = (state_q == ST_PLAY) && status_code[STATUS_FINISH_BIT] && !finished_q[cur_q];

  // Next-state logic: a finish takes priority over the slice wrap, so the turn advances once.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    presc_d    = presc_q;
    finished_d = finished_q;
    count_d    = count_q;
    rank_d     = rank_q;
    win_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        presc_d = '0;
        if (start) begin
          state_d    = ST_PLAY;
          cur_d      = '0;
          finished_d = '0;
          count_d    = '0;
          rank_d     = '0;
        end
      end
      ST_PLAY: begin
        if (fin_now) begin
          finished_d = finished_q | cur_onehot;
          for (int k = 0; k < N_PLAYERS; k++) begin
            if (count_q == CNT_W'(k)) begin
              rank_d[k*ID_W +: ID_W] = cur_q;
            end
          end
          count_d = count_inc;
          win_d   = 1'b1;
          presc_d = '0;
          cur_d   = pick_next;
          if (count_inc == CNT_W'(N_PLAYERS)) begin
            state_d = ST_OVER;
            cur_d   = cur_q;
          end
`ifdef GAME_SCHED_AUTORANK_EN
          // Exactly one unfinished player remains: rank it now, it never gets to finish itself.
          else if ((N_PLAYERS >= 2) && (count_inc == CNT_W'(N_PLAYERS - 1))) begin
            for (int k = 0; k < N_PLAYERS; k++) begin
              if (count_inc == CNT_W'(k)) begin
                rank_d[k*ID_W +: ID_W] = pick_next;
              end
            end
            count_d    = CNT_W'(N_PLAYERS);
            finished_d = '1;
            state_d    = ST_OVER;
            cur_d      = cur_q;
          end
`endif
        end else if (presc_q == PRE_W'(DIV - 1)) begin
          presc_d = '0;
          cur_d   = pick_none ? cur_q : pick_next;
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, prescaler and rank registers; reset aborts any game in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      presc_q    <= '0;
      finished_q <= '0;
      count_q    <= '0;
      rank_q     <= '0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      presc_q    <= presc_d;
      finished_q <= finished_d;
      count_q    <= count_d;
      rank_q     <= rank_d;
      win_q      <= win_d;
    end
  end

endmodule
